// File: rtl/pipe_stage_reg.sv
// Y86-64 pipeline stage register with stall/bubble control, a valid flag,
// a saturating consecutive-stall counter with timeout, and a sticky error
// for simultaneous stall and bubble requests.
module pipe_stage_reg #(
  parameter int unsigned      NUM_VAL   = 2,
  parameter int unsigned      VAL_W     = 64,
  parameter logic [2:0]       STAT_BUB  = 3'd0,
  parameter logic [3:0]       BUB_ICODE = 4'h1,
  parameter logic [3:0]       RNONE     = 4'hF,
  parameter int unsigned      CNT_W     = 4,
  parameter logic [CNT_W-1:0] MAX_STALL = 4'd8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     stall,
  input  logic                     bubble,
  input  logic [2:0]               in_stat,
  input  logic [3:0]               in_icode,
  input  logic [3:0]               in_ifun,
  input  logic [3:0]               in_rA,
  input  logic [3:0]               in_rB,
  input  logic [NUM_VAL*VAL_W-1:0] in_val,
  output logic [2:0]               out_stat,
  output logic [3:0]               out_icode,
  output logic [3:0]               out_ifun,
  output logic [3:0]               out_rA,
  output logic [3:0]               out_rB,
  output logic [NUM_VAL*VAL_W-1:0] out_val,
  output logic                     out_valid,
  output logic [CNT_W-1:0]         stall_cnt,
  output logic                     stall_timeout,
  output logic                     ctl_err
);

  logic [2:0]               r_stat;
  logic [3:0]               r_icode;
  logic [3:0]               r_ifun;
  logic [3:0]               r_rA;
  logic [3:0]               r_rB;
  logic [NUM_VAL*VAL_W-1:0] r_val;
  logic                     r_valid;
  logic [CNT_W-1:0]         r_stall_cnt;
  logic                     r_ctl_err;
  logic                     w_cnt_sat;

  assign w_cnt_sat = (r_stall_cnt == '1);

  // Datapath: stall holds (even over bubble), bubble injects a NOP, otherwise load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat  <= STAT_BUB;
      r_icode <= BUB_ICODE;
      r_ifun  <= '0;
      r_rA    <= RNONE;
      r_rB    <= RNONE;
      r_val   <= '0;
      r_valid <= 1'b0;
    end else if (stall) begin
      r_stat  <= r_stat;
      r_icode <= r_icode;
      r_ifun  <= r_ifun;
      r_rA    <= r_rA;
      r_rB    <= r_rB;
      r_val   <= r_val;
      r_valid <= r_valid;
    end else if (bubble) begin
      r_stat  <= STAT_BUB;
      r_icode <= BUB_ICODE;
      r_ifun  <= '0;
      r_rA    <= RNONE;
      r_rB    <= RNONE;
      r_val   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_stat  <= in_stat;
      r_icode <= in_icode;
      r_ifun  <= in_ifun;
      r_rA    <= in_rA;
      r_rB    <= in_rB;
      r_val   <= in_val;
      r_valid <= 1'b1;
    end
  end

  // Consecutive-stall counter: counts up while stalled, saturates, clears otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (stall) begin
      if (!w_cnt_sat) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end else begin
      r_stall_cnt <= '0;
    end
  end

  // Sticky flag for a stall and a bubble requested in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctl_err <= 1'b0;
    end else if (stall && bubble) begin
      r_ctl_err <= 1'b1;
    end
  end

  assign out_stat      = r_stat;
  assign out_icode     = r_icode;
  assign out_ifun      = r_ifun;
  assign out_rA        = r_rA;
  assign out_rB        = r_rB;
  assign out_val       = r_val;
  assign out_valid     = r_valid;
  assign stall_cnt     = r_stall_cnt;
  assign stall_timeout = (r_stall_cnt >= MAX_STALL);
  assign ctl_err       = r_ctl_err;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: a vector table for the single-cycle
// behaviour plus hand-written reset, saturation and conflict sequences.
module tb_pipe_stage_reg;

  logic         clk;
  logic         rst_n;
  logic         stall;
  logic         bubble;
  logic [2:0]   in_stat;
  logic [3:0]   in_icode;
  logic [3:0]   in_ifun;
  logic [3:0]   in_rA;
  logic [3:0]   in_rB;
  logic [127:0] in_val;
  logic [255:0] in_val4;

  logic [2:0]   out_stat;
  logic [3:0]   out_icode;
  logic [3:0]   out_ifun;
  logic [3:0]   out_rA;
  logic [3:0]   out_rB;
  logic [127:0] out_val;
  logic         out_valid;
  logic [3:0]   stall_cnt;
  logic         stall_timeout;
  logic         ctl_err;

  logic [2:0]   out_stat4;
  logic [3:0]   out_icode4;
  logic [3:0]   out_ifun4;
  logic [3:0]   out_rA4;
  logic [3:0]   out_rB4;
  logic [255:0] out_val4;
  logic         out_valid4;
  logic [3:0]   stall_cnt4;
  logic         stall_timeout4;
  logic         ctl_err4;

  int n_chk;
  int n_err;

  pipe_stage_reg dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .bubble(bubble),
    .in_stat(in_stat), .in_icode(in_icode), .in_ifun(in_ifun),
    .in_rA(in_rA), .in_rB(in_rB), .in_val(in_val),
    .out_stat(out_stat), .out_icode(out_icode), .out_ifun(out_ifun),
    .out_rA(out_rA), .out_rB(out_rB), .out_val(out_val),
    .out_valid(out_valid), .stall_cnt(stall_cnt),
    .stall_timeout(stall_timeout), .ctl_err(ctl_err)
  );

  pipe_stage_reg #(.NUM_VAL(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .bubble(bubble),
    .in_stat(in_stat), .in_icode(in_icode), .in_ifun(in_ifun),
    .in_rA(in_rA), .in_rB(in_rB), .in_val(in_val4),
    .out_stat(out_stat4), .out_icode(out_icode4), .out_ifun(out_ifun4),
    .out_rA(out_rA4), .out_rB(out_rB4), .out_val(out_val4),
    .out_valid(out_valid4), .stall_cnt(stall_cnt4),
    .stall_timeout(stall_timeout4), .ctl_err(ctl_err4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic         s;
    logic         b;
    logic [2:0]   stat;
    logic [3:0]   icode;
    logic [3:0]   ifun;
    logic [3:0]   ra;
    logic [3:0]   rb;
    logic [127:0] val;
    logic [2:0]   e_stat;
    logic [3:0]   e_icode;
    logic [3:0]   e_ifun;
    logic [3:0]   e_ra;
    logic [3:0]   e_rb;
    logic [127:0] e_val;
    logic         e_valid;
    logic [3:0]   e_cnt;
    logic         e_to;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] st, input logic [3:0] ic, input logic [3:0] fn,
                       input logic [3:0] ra, input logic [3:0] rb, input logic [127:0] v);
    in_stat  = st;
    in_icode = ic;
    in_ifun  = fn;
    in_rA    = ra;
    in_rB    = rb;
    in_val   = v;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".stat"},  256'(out_stat),      256'(3'd0));
    chk({tag, ".icode"}, 256'(out_icode),     256'(4'h1));
    chk({tag, ".ifun"},  256'(out_ifun),      256'(4'h0));
    chk({tag, ".rA"},    256'(out_rA),        256'(4'hF));
    chk({tag, ".rB"},    256'(out_rB),        256'(4'hF));
    chk({tag, ".val"},   256'(out_val),       256'(128'h0));
    chk({tag, ".valid"}, 256'(out_valid),     256'(1'b0));
    chk({tag, ".cnt"},   256'(stall_cnt),     256'(4'd0));
    chk({tag, ".to"},    256'(stall_timeout), 256'(1'b0));
    chk({tag, ".err"},   256'(ctl_err),       256'(1'b0));
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;

    //            s     b     stat  icode ifun  rA    rB    val                          e_stat e_icode e_ifun e_rA e_rB e_val                    valid cnt  to
    tbl[0] = '{1'b0, 1'b0, 3'd1, 4'h3, 4'h0, 4'hF, 4'h2, {64'h100, 64'h0A},   3'd1, 4'h3, 4'h0, 4'hF, 4'h2, {64'h100, 64'h0A},   1'b1, 4'd0, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 3'd1, 4'h6, 4'h1, 4'h3, 4'h4, {64'h200, 64'h300},  3'd1, 4'h6, 4'h1, 4'h3, 4'h4, {64'h200, 64'h300},  1'b1, 4'd0, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 3'd2, 4'h7, 4'h2, 4'h5, 4'h6, {64'hAAA, 64'hBBB},  3'd1, 4'h6, 4'h1, 4'h3, 4'h4, {64'h200, 64'h300},  1'b1, 4'd1, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 3'd3, 4'h8, 4'h3, 4'h6, 4'h7, {64'hCCC, 64'hDDD},  3'd1, 4'h6, 4'h1, 4'h3, 4'h4, {64'h200, 64'h300},  1'b1, 4'd2, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 3'd4, 4'h9, 4'h4, 4'h7, 4'h8, {64'hEEE, 64'hFFF},  3'd1, 4'h6, 4'h1, 4'h3, 4'h4, {64'h200, 64'h300},  1'b1, 4'd3, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 3'd1, 4'h2, 4'h0, 4'h1, 4'h5, {64'h7, 64'h8},      3'd1, 4'h2, 4'h0, 4'h1, 4'h5, {64'h7, 64'h8},      1'b1, 4'd0, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 3'd4, 4'h5, 4'h5, 4'h5, 4'h5, {64'h1, 64'h2},      3'd0, 4'h1, 4'h0, 4'hF, 4'hF, 128'h0,              1'b0, 4'd0, 1'b0};
    tbl[7] = '{1'b0, 1'b0, 3'd1, 4'h5, 4'h0, 4'h2, 4'h3, {64'h11, 64'h22},    3'd1, 4'h5, 4'h0, 4'h2, 4'h3, {64'h11, 64'h22},    1'b1, 4'd0, 1'b0};

    rst_n   = 1'b0;
    stall   = 1'b0;
    bubble  = 1'b0;
    drive(3'd0, 4'h0, 4'h0, 4'h0, 4'h0, 128'h0);
    in_val4 = {64'hDEADBEEF, 64'h3, 64'h100, 64'h0A};
    tick();
    tick();
    chk_reset("por");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("known_after_release", 256'($isunknown({out_valid, stall_cnt, ctl_err, out_icode})), 256'(1'b0));

    // Table-driven single-cycle behaviour
    for (int i = 0; i < 8; i++) begin
      stall  = tbl[i].s;
      bubble = tbl[i].b;
      drive(tbl[i].stat, tbl[i].icode, tbl[i].ifun, tbl[i].ra, tbl[i].rb, tbl[i].val);
      tick();
      chk($sformatf("v%0d.stat", i),  256'(out_stat),      256'(tbl[i].e_stat));
      chk($sformatf("v%0d.icode", i), 256'(out_icode),     256'(tbl[i].e_icode));
      chk($sformatf("v%0d.ifun", i),  256'(out_ifun),      256'(tbl[i].e_ifun));
      chk($sformatf("v%0d.rA", i),    256'(out_rA),        256'(tbl[i].e_ra));
      chk($sformatf("v%0d.rB", i),    256'(out_rB),        256'(tbl[i].e_rb));
      chk($sformatf("v%0d.val", i),   256'(out_val),       256'(tbl[i].e_val));
      chk($sformatf("v%0d.valid", i), 256'(out_valid),     256'(tbl[i].e_valid));
      chk($sformatf("v%0d.cnt", i),   256'(stall_cnt),     256'(tbl[i].e_cnt));
      chk($sformatf("v%0d.to", i),    256'(stall_timeout), 256'(tbl[i].e_to));
      chk($sformatf("v%0d.err", i),   256'(ctl_err),       256'(1'b0));
      if (i == 0) begin
        chk("nv4.field3", 256'(out_val4[255:192]), 256'(64'hDEADBEEF));
        chk("nv4.val",    out_val4, {64'hDEADBEEF, 64'h3, 64'h100, 64'h0A});
        chk("nv4.valid",  256'(out_valid4), 256'(1'b1));
        chk("nv4.icode",  256'(out_icode4), 256'(4'h3));
      end
    end

    // Asynchronous reset mid-cycle with valid contents loaded
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;

    // Asynchronous reset in the middle of a stall
    drive(3'd1, 4'h4, 4'h0, 4'h1, 4'h2, {64'h5, 64'h6});
    tick();
    stall = 1'b1;
    tick();
    tick();
    tick();
    chk("pre_rst_stall.cnt", 256'(stall_cnt), 256'(4'd3));
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("rst_stall");
    @(negedge clk);
    rst_n = 1'b1;

    // Long stall: timeout at 8, saturation at 15, both clear after release
    for (int i = 1; i <= 20; i++) begin
      tick();
      chk($sformatf("sat%0d.cnt", i), 256'(stall_cnt), 256'((i > 15) ? 4'd15 : 4'(i)));
      chk($sformatf("sat%0d.to", i),  256'(stall_timeout), 256'(i >= 8));
    end
    stall = 1'b0;
    tick();
    chk("sat_rel.cnt", 256'(stall_cnt), 256'(4'd0));
    chk("sat_rel.to",  256'(stall_timeout), 256'(1'b0));

    // Stall and bubble together: hold, count, and latch the error until reset
    drive(3'd1, 4'h4, 4'h0, 4'h1, 4'h2, {64'h5, 64'h6});
    tick();
    chk("cf_load.icode", 256'(out_icode), 256'(4'h4));
    chk("cf_load.err",   256'(ctl_err), 256'(1'b0));
    stall  = 1'b1;
    bubble = 1'b1;
    drive(3'd2, 4'h9, 4'h3, 4'h7, 4'h8, {64'h99, 64'h98});
    tick();
    chk("cf.icode", 256'(out_icode), 256'(4'h4));
    chk("cf.val",   256'(out_val), 256'({64'h5, 64'h6}));
    chk("cf.valid", 256'(out_valid), 256'(1'b1));
    chk("cf.cnt",   256'(stall_cnt), 256'(4'd1));
    chk("cf.err",   256'(ctl_err), 256'(1'b1));
    stall  = 1'b0;
    bubble = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(3'd1, 4'(i + 2), 4'h0, 4'h3, 4'h4, {64'h0, 64'(i)});
      tick();
      chk($sformatf("cf_after%0d.icode", i), 256'(out_icode), 256'(4'(i + 2)));
      chk($sformatf("cf_after%0d.err", i),   256'(ctl_err), 256'(1'b1));
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("cf_rst.err", 256'(ctl_err), 256'(1'b0));
    chk_reset("cf_rst");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised Y86-64 pipeline stage register, successor to the fixed-width F->D register.
- One instance sits at each stage boundary (F->D, D->E, E->M, M->W) and carries stat, icode, ifun, two register IDs and NUM_VAL 64-bit value fields.
- Adds what the fixed-width register lacks: stall (hold), bubble (NOP injection), a valid flag, a saturating consecutive-stall counter with timeout flag, and a sticky control-conflict error.

Parameters:
- NUM_VAL, 2, number of value fields carried (valC/valP at D; valA/valB/valE/valM elsewhere); range 1..4
- VAL_W, 64, width of each value field
- STAT_BUB, 3'd0, stat code written on bubble/reset
- BUB_ICODE, 4'h1, icode written on bubble/reset (NOP)
- RNONE, 4'hF, register ID written on bubble/reset
- CNT_W, 4, width of the stall counter
- MAX_STALL, 4'd8, consecutive-stall count at which stall_timeout asserts

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  hold current contents
- bubble  in  1  load NOP instead of inputs
- in_stat  in  3  upstream stat
- in_icode  in  4  upstream icode
- in_ifun  in  4  upstream ifun
- in_rA  in  4  upstream register A ID
- in_rB  in  4  upstream register B ID
- in_val  in  NUM_VAL*VAL_W  packed value fields, field k at [k*VAL_W +: VAL_W]
- out_stat  out  3  registered stat
- out_icode  out  4  registered icode
- out_ifun  out  4  registered ifun
- out_rA  out  4  registered rA
- out_rB  out  4  registered rB
- out_val  out  NUM_VAL*VAL_W  registered value fields
- out_valid  out  1  1 = contents came from a real load, 0 = bubble/reset
- stall_cnt  out  CNT_W  consecutive stall cycles, saturating
- stall_timeout  out  1  stall_cnt >= MAX_STALL
- ctl_err  out  1  sticky: stall and bubble seen asserted together

Behaviour:
- Reset (rst_n=0, asynchronous, takes effect immediately, including mid-stall):
  - out_stat=STAT_BUB, out_icode=BUB_ICODE, out_ifun=0, out_rA=out_rB=RNONE, out_val=0, out_valid=0
  - stall_cnt=0, stall_timeout=0, ctl_err=0
- Each rising clk edge with rst_n=1, evaluated in this priority order:
  1. stall=1 (regardless of bubble): all data outputs and out_valid hold. If bubble=1 in the same cycle, ctl_err sets and stays set until reset.
  2. bubble=1, stall=0: load the reset pattern above into the data outputs; out_valid=0.
  3. Neither asserted: load all in_* into out_*; out_valid=1.
- Latency: one cycle from in_* to out_*. No combinational path from in_* to out_*.
- stall_cnt:
  - Increments on each clk edge with stall=1 and saturates at 2^CNT_W-1 (no wrap).
  - Clears to 0 on any clk edge with stall=0.
- stall_timeout is combinational from registered stall_cnt (stall_cnt >= MAX_STALL). It deasserts the cycle after stall drops. It is status only and does not alter datapath behaviour.
- Bubble does not touch stall_cnt except through its clear-on-no-stall rule.
- X on stall/bubble is an error condition; the bench checks none occurs after reset release.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with outputs loaded -> outputs immediately stat=0, icode=1, ifun=0, rA=rB=F, val=0, valid=0, stall_cnt=0, ctl_err=0.
- Normal flow: drive stat=1, icode=3, ifun=0, rA=F, rB=2, val={64'h100,64'h0A} with stall=bubble=0 -> next edge outputs equal inputs, valid=1. A new input each cycle appears exactly one cycle later.
- Stall hold: load icode=6/ifun=1, then stall=1 for 3 cycles while inputs change -> outputs unchanged, stall_cnt=1,2,3; stall=0 -> new input loaded, stall_cnt=0.
- Bubble: after a valid load, bubble=1 one cycle -> stat=0, icode=1, rA=rB=F, val=0, valid=0; next cycle normal load resumes.
- Timeout/saturation (CNT_W=4, MAX_STALL=8): stall held 20 cycles -> stall_timeout rises when stall_cnt reaches 8, stall_cnt stops at 15; release -> both 0 after one edge.
- Conflict and parameter sweep: stall=bubble=1 one cycle -> outputs hold, ctl_err=1 and stays 1 until rst_n=0. Repeat the normal-flow check with NUM_VAL=4, field 3 = 64'hDEADBEEF -> lands at out_val[255:192].
